// File: rtl/vga_pkg.sv
// XGA 1024x768@60 raster timing constants shared by the timing generator
// and the downstream drawing stages.
package vga_pkg;

    localparam int CNT_W    = 11;

    localparam int H_ACTIVE = 1024;
    localparam int H_FRONT  = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BACK   = 160;

    localparam int V_ACTIVE = 768;
    localparam int V_FRONT  = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BACK   = 29;

    localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with blank/sync flags derived
// from the next-state count so they align with the registered count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 1024,
    parameter int FRONT  = 24,
    parameter int SYNC   = 136,
    parameter int BACK   = 160
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             blnk,
    output logic             sync,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    if (TOTAL >= 2048) begin : g_total_too_wide
        $error("vga_axis_counter: TOTAL must be below 2048");
    end

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_W      = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FRONT + SYNC);

    logic [CNT_W-1:0] count_q, count_d;
    logic             blnk_q, blnk_d;
    logic             sync_q, sync_d;

    // wrap is combinational so the next axis advances on the same edge.
    always_comb begin
        wrap    = inc && (count_q == LAST);
        count_d = count_q;
        if (inc) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        blnk_d = (count_d >= ACT_W);
        sync_d = (count_d >= SYNC_START) && (count_d < SYNC_END);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            blnk_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blnk_q  <= blnk_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign blnk  = blnk_q;
    assign sync  = sync_q;

endmodule

// File: rtl/vga_timing.sv
// Free-running XGA raster timing generator: registered counts, sync, blank
// and a first-pixel-of-frame pulse, all zero-skew with each other.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACT = vga_pkg::H_ACTIVE,
    parameter int H_FP  = vga_pkg::H_FRONT,
    parameter int H_SW  = vga_pkg::H_SYNC,
    parameter int H_BP  = vga_pkg::H_BACK,
    parameter int V_ACT = vga_pkg::V_ACTIVE,
    parameter int V_FP  = vga_pkg::V_FRONT,
    parameter int V_SW  = vga_pkg::V_SYNC,
    parameter int V_BP  = vga_pkg::V_BACK
) (
    input  logic             pclk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             frame_start
);

    logic h_wrap;
    logic v_wrap;
    logic frame_start_q;

    vga_axis_counter #(
        .ACTIVE(H_ACT), .FRONT(H_FP), .SYNC(H_SW), .BACK(H_BP)
    ) u_h (
        .pclk  (pclk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .count (hcount),
        .blnk  (hblnk),
        .sync  (hsync),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACT), .FRONT(V_FP), .SYNC(V_SW), .BACK(V_BP)
    ) u_v (
        .pclk  (pclk),
        .rst_n (rst_n),
        .inc   (h_wrap),
        .count (vcount),
        .blnk  (vblnk),
        .sync  (vsync),
        .wrap  (v_wrap)
    );

    // Both axes wrapping together means the next pixel is (0,0).
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= v_wrap;
        end
    end

    assign frame_start = frame_start_q;

endmodule
